reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//   Turns the KEY0 push-button into a controlled reset sequence for the neural engine.
//   - Synchronises and debounces the raw active-low key.
//   - Holds the engine in reset for a fixed time, then releases it.
//   - Waits for the engine's ready handshake, with a timeout.
//   - Reports sequence state on LED0..LED9.
//   Sits between the board pins and the engine's reset/ready interface.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  consecutive stable samples before a key level is accepted (10 ms @ 50 MHz)
//   RST_HOLD_CYCLES  16      cycles eng_rst_n is held low per reset sequence (>=1)
//   READY_TIMEOUT    1024    WAIT-state cycles allowed for eng_ready before FAULT (>=1)
// PORTS
//   clk        in   1   single system clock; all logic on posedge
//   rst_n      in   1   synchronous, active-low reset
//   key0_n     in   1   raw KEY0 pin, active-low (0 = pressed), asynchronous to clk
//   eng_ready  in   1   engine ready handshake; sampled only in WAIT and RUN
//   eng_rst_n  out  1   active-low reset to engine; registered
//   seq_busy   out  1   1 while in ASSERT or WAIT
//   seq_error  out  1   1 while in FAULT
//   led        out  10  status LEDs; led[i] drives LEDi, 1 = lit
// BEHAVIOUR
//   Reset (rst_n=0 at posedge):
//     state=ASSERT, hold/timeout counters=0, eng_rst_n=0, seq_busy=1, seq_error=0,
//     led=10'h001, debouncer stable level=1 (released).
//   Key path:
//     - 2-flop synchroniser, reset value 1.
//     - Debounce counter restarts whenever the synced level equals the stable level.
//     - Stable level takes the synced level once DEBOUNCE_CYCLES consecutive differing samples are seen.
//     - press = 1-cycle pulse on a stable 1->0 transition; release produces no event.
//     - Latency from a clean key edge to press: 2 + DEBOUNCE_CYCLES + 1 cycles.
//   FSM (all outputs registered, decoded from next state):
//     IDLE   : eng_rst_n=1; entered only from RUN? no -- IDLE is unused after reset; encoding reserved.
//     ASSERT : eng_rst_n=0.
//              - Hold counter runs 0..RST_HOLD_CYCLES-1; -> WAIT when it reaches RST_HOLD_CYCLES-1.
//              - eng_rst_n is therefore low exactly RST_HOLD_CYCLES cycles.
//     WAIT   : eng_rst_n=1; timeout counter increments each cycle.
//              - eng_ready=1 -> RUN next cycle, including on the first WAIT cycle.
//              - Counter reaching READY_TIMEOUT-1 with eng_ready=0 -> FAULT.
//     RUN    : eng_rst_n=1.
//              - eng_ready falling to 0 -> FAULT next cycle.
//     FAULT  : eng_rst_n=1, seq_error=1; remains here until press.
//   press in ANY state -> ASSERT next cycle; hold and timeout counters cleared.
//   Priority: press > eng_ready > timeout.
//     - Simultaneous press and timeout in WAIT -> ASSERT.
//     - Simultaneous ready and timeout -> RUN.
//   rst_n low mid-sequence overrides everything and restarts from ASSERT at the next cycle.
//   LED map: led[0]=ASSERT, led[1]=WAIT, led[2]=RUN, led[9]=FAULT.
//   led[8:3]=0 unless the optional feature is enabled; exactly one of led[0,1,2,9] is lit at a time.
// CONFIGURATION
//   `RESET_SEQ_PROGRESS_EN
//     defined : in WAIT, led[8:3] is a thermometer of timeout progress.
//               led[3+k]=1 when counter >= (k+1)*READY_TIMEOUT/7, k=0..5.
//               led[8:3]=0 in all other states.
//     undefined : led[8:3] tied to 0; no comparators synthesised.
// STRUCTURE
//   Package reset_seq_pkg:
//     - typedef enum logic [2:0] {IDLE, ASSERT, WAIT, RUN, FAULT} seq_state_t
//     - LED index localparams LED_ASSERT=0, LED_WAIT=1, LED_RUN=2, LED_FAULT=9
//     - NUM_LEDS=10
//   Sub-module key_debounce:
//     - Synchroniser, debounce counter and press pulse generator.
//     - Params DEBOUNCE_CYCLES; ports clk, rst_n, key_n, stable, press.
//   Counter widths: $clog2 of their parameter, minimum 1 bit.
// TESTING (bench params DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3, READY_TIMEOUT=8)
//   1. Release rst_n, eng_ready=1 from 2nd WAIT cycle -> eng_rst_n low exactly 3 cycles,
//      then RUN with led=10'h004, seq_busy=0.
//   2. key0_n toggles every 2 cycles for 20 cycles -> no press, state unchanged;
//      then held 0 for 8 cycles -> exactly one press, led=10'h001.
//   3. eng_ready held 0 -> FAULT after 8 WAIT cycles, led=10'h200, seq_error=1;
//      a clean press -> ASSERT, seq_error=0.
//   4. Press during ASSERT on hold count 1 -> count restarts;
//      eng_rst_n low 3 cycles after re-entry.
//   5. In RUN, drop eng_ready for 1 cycle -> FAULT next cycle, eng_rst_n stays 1.
//   6. Assert rst_n=0 mid-WAIT -> next cycle eng_rst_n=0, led=10'h001, seq_error=0;
//      repeat tests 1 and 3 with `RESET_SEQ_PROGRESS_EN defined:
//      led[8:3] fills monotonically during WAIT and clears on exit.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the KEY0-driven engine reset sequencer.
// State encoding, LED bit positions and counter sizing helper.
package reset_seq_pkg;

  typedef enum logic [2:0] {IDLE, ASSERT, WAIT, RUN, FAULT} seq_state_t;

  localparam int NUM_LEDS   = 10;
  localparam int LED_ASSERT = 0;
  localparam int LED_WAIT   = 1;
  localparam int LED_RUN    = 2;
  localparam int LED_FAULT  = 9;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces an active-low key; press is a 1-cycle pulse on a stable 1->0.
// Clean edge to press pulse: 2 + DEBOUNCE_CYCLES + 1 cycles.
module key_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic stable,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          stable_dly_q;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample matching the accepted level restarts the run of differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = stable_dly_q & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= key_n;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// KEY0 -> engine reset sequence: hold reset, release, await ready with timeout, show state on LEDs.
// Define RESET_SEQ_PROGRESS_EN to show WAIT timeout progress as a thermometer on led[8:3].
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int READY_TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key0_n,
  input  logic                eng_ready,
  output logic                eng_rst_n,
  output logic                seq_busy,
  output logic                seq_error,
  output logic [NUM_LEDS-1:0] led
);

  localparam int HW = cnt_width(RST_HOLD_CYCLES);
  localparam int TW = cnt_width(READY_TIMEOUT);

  logic press;
  logic key_stable_unused;

  seq_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          eng_rst_n_q, eng_rst_n_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [NUM_LEDS-1:0] led_q, led_d;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key0_n),
    .stable (key_stable_unused),
    .press  (press)
  );

  // A press wins over ready, and ready wins over the timeout.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tmo_d   = tmo_q;
    if (press) begin
      state_d = ASSERT;
      hold_d  = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        ASSERT: begin
          if (hold_q == HW'(RST_HOLD_CYCLES - 1)) begin
            state_d = WAIT;
            hold_d  = '0;
            tmo_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        WAIT: begin
          if (eng_ready) begin
            state_d = RUN;
            tmo_d   = '0;
          end else if (tmo_q == TW'(READY_TIMEOUT - 1)) begin
            state_d = FAULT;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        RUN: begin
          if (!eng_ready) state_d = FAULT;
        end
        FAULT: ;
        default: begin
          state_d = ASSERT;
          hold_d  = '0;
          tmo_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_comb begin
    eng_rst_n_d = (state_d != ASSERT);
    busy_d      = (state_d == ASSERT) || (state_d == WAIT);
    err_d       = (state_d == FAULT);
    led_d       = '0;
    case (state_d)
      ASSERT:  led_d[LED_ASSERT] = 1'b1;
      WAIT:    led_d[LED_WAIT]   = 1'b1;
      RUN:     led_d[LED_RUN]    = 1'b1;
      FAULT:   led_d[LED_FAULT]  = 1'b1;
      default: ;
    endcase
`ifdef RESET_SEQ_PROGRESS_EN
    for (int k = 0; k < 6; k++) begin
      if (state_d == WAIT && tmo_d >= TW'(((k + 1) * READY_TIMEOUT) / 7))
        led_d[LED_RUN + 1 + k] = 1'b1;
    end
`else
    led_d[LED_FAULT-1:LED_RUN+1] = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ASSERT;
      hold_q      <= '0;
      tmo_q       <= '0;
      eng_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      led_q       <= NUM_LEDS'(1) << LED_ASSERT;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      eng_rst_n_q <= eng_rst_n_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      led_q       <= led_d;
    end
  end

  assign eng_rst_n = eng_rst_n_q;
  assign seq_busy  = busy_q;
  assign seq_error = err_q;
  assign led       = led_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: vector table, directed corner sequences and a randomized run
// compared each cycle against a phase/elapsed-time reference model.
module tb_reset_sequencer;

  localparam int D = 4;
  localparam int H = 3;
  localparam int T = 8;

  localparam int M_ASSERT = 0;
  localparam int M_WAIT   = 1;
  localparam int M_RUN    = 2;
  localparam int M_FAULT  = 3;

`ifdef RESET_SEQ_PROGRESS_EN
  localparam logic [9:0] P_EL1 = 10'h008;
`else
  localparam logic [9:0] P_EL1 = 10'h000;
`endif

  logic       clk = 1'b0;
  logic       rst_n, key0_n, eng_ready;
  logic       eng_rst_n, seq_busy, seq_error;
  logic [9:0] led;

  always #5 clk = ~clk;

  reset_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .RST_HOLD_CYCLES (H),
    .READY_TIMEOUT   (T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key0_n    (key0_n),
    .eng_ready (eng_ready),
    .eng_rst_n (eng_rst_n),
    .seq_busy  (seq_busy),
    .seq_error (seq_error),
    .led       (led)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
  endtask

  // Reference model: sequencer phase plus cycles elapsed in it; key path as a sample history.
  int  m_phase;
  int  m_el;
  bit  m_k1, m_k2, m_stable, m_press, m_fall;
  bit  m_syn[$];
  bit  inj = 1'b0;

  task automatic model_step();
    bit p, syn, all_diff;
    if (!rst_n) begin
      m_phase = M_ASSERT; m_el = 0;
      m_k1 = 1'b1; m_k2 = 1'b1; m_stable = 1'b1;
      m_press = 1'b0; m_fall = 1'b0;
      m_syn.delete();
      return;
    end
    p = m_press | inj;
    if (p) begin
      m_phase = M_ASSERT; m_el = 0;
    end else if (m_phase == M_ASSERT) begin
      if (m_el + 1 >= H) begin m_phase = M_WAIT; m_el = 0; end
      else m_el++;
    end else if (m_phase == M_WAIT) begin
      if (eng_ready) begin m_phase = M_RUN; m_el = 0; end
      else if (m_el + 1 >= T) begin m_phase = M_FAULT; m_el = 0; end
      else m_el++;
    end else if (m_phase == M_RUN && !eng_ready) begin
      m_phase = M_FAULT;
    end
    syn = m_k2; m_k2 = m_k1; m_k1 = key0_n;
    m_press = m_fall; m_fall = 1'b0;
    m_syn.push_back(syn);
    if (m_syn.size() > D) void'(m_syn.pop_front());
    all_diff = (m_syn.size() == D);
    foreach (m_syn[i]) if (m_syn[i] == m_stable) all_diff = 1'b0;
    if (all_diff) begin
      m_stable = syn;
      m_syn.delete();
      if (!m_stable) m_fall = 1'b1;
    end
  endtask

  always @(posedge clk) model_step();

  function automatic logic [9:0] exp_led();
    logic [9:0] l = '0;
    case (m_phase)
      M_ASSERT: l[0] = 1'b1;
      M_WAIT:   l[1] = 1'b1;
      M_RUN:    l[2] = 1'b1;
      default:  l[9] = 1'b1;
    endcase
`ifdef RESET_SEQ_PROGRESS_EN
    if (m_phase == M_WAIT)
      for (int k = 0; k < 6; k++) if (m_el >= ((k + 1) * T) / 7) l[3 + k] = 1'b1;
`endif
    return l;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    chk("model_eng_rst_n", eng_rst_n, m_phase != M_ASSERT);
    chk("model_seq_busy", seq_busy, m_phase == M_ASSERT || m_phase == M_WAIT);
    chk("model_seq_error", seq_error, m_phase == M_FAULT);
    chk("model_led", led, exp_led());
  endtask

  typedef struct {
    bit         rst;
    bit         rdy;
    bit         e_rst_n;
    bit         e_busy;
    bit         e_err;
    logic [9:0] e_led;
  } vec_t;

  vec_t tv[7];

  initial begin
    int waitc, lowc, asrt, key_left, rdy_left;
    bit done;
    logic [5:0] prog, prev;

    rst_n = 1'b0; key0_n = 1'b1; eng_ready = 1'b0;

    // Test 1: reset release, hold low 3 cycles, ready on 2nd WAIT cycle -> RUN
    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h001};
    tv[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h001};
    tv[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h001};
    tv[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h002};
    tv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 10'h002 | P_EL1};
    tv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h004};
    tv[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'h004};
    for (int i = 0; i < 7; i++) begin
      rst_n = tv[i].rst; eng_ready = tv[i].rdy;
      cyc();
      chk($sformatf("t1_eng_rst_n[%0d]", i), eng_rst_n, tv[i].e_rst_n);
      chk($sformatf("t1_busy[%0d]", i), seq_busy, tv[i].e_busy);
      chk($sformatf("t1_err[%0d]", i), seq_error, tv[i].e_err);
      chk($sformatf("t1_led[%0d]", i), led, tv[i].e_led);
    end

    // Test 2: bouncing key gives no press; held low gives exactly one press
    for (int i = 0; i < 20; i++) begin
      key0_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      cyc();
      chk("t2_bounce_led", led, 10'h004);
    end
    key0_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 7) chk("t2_before_press", led, 10'h004);
      if (i == 8) chk("t2_press_led", led, 10'h001);
    end
    key0_n = 1'b1;
    asrt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (led[0]) asrt++;
    end
    chk("t2_single_press", asrt, 2);
    chk("t2_back_to_run", led, 10'h004);

    // Test 3: no ready -> FAULT after 8 WAIT cycles; clean press recovers
    eng_ready = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    waitc = 0; done = 1'b0; prev = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc();
      if (led[1]) begin
        waitc++;
        prog = led[8:3];
`ifdef RESET_SEQ_PROGRESS_EN
        chk("t3_prog_monotonic", (prog & prev) == prev && (prog & (prog + 6'd1)) == 0, 1);
`else
        chk("t3_prog_off", prog, 6'h0);
`endif
        prev = prog;
      end
      if (led == 10'h200) done = 1'b1;
    end
    chk("t3_reached_fault", done, 1);
    chk("t3_wait_cycles", waitc, T);
    chk("t3_fault_err", seq_error, 1);
    chk("t3_fault_rst_n", eng_rst_n, 1);
    key0_n = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    key0_n = 1'b1;
    chk("t3_press_led", led, 10'h001);
    chk("t3_press_err", seq_error, 0);
    chk("t3_press_rst_n", eng_rst_n, 0);
    for (int i = 0; i < 12; i++) cyc();

    // Test 4: press on hold count 1 restarts the hold
    eng_ready = 1'b1; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    force dut.press = 1'b1;
    inj = 1'b1;
    cyc();
    release dut.press;
    inj = 1'b0;
    chk("t4_reenter_led", led, 10'h001);
    lowc = 1; done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc();
      if (eng_rst_n == 1'b0) lowc++;
      else done = 1'b1;
    end
    chk("t4_low_cycles", lowc, H);
    chk("t4_after_hold_led", led, 10'h002);

    // Test 5: one-cycle ready drop in RUN -> FAULT, reset stays released
    cyc();
    chk("t5_run", led, 10'h004);
    eng_ready = 1'b0;
    cyc();
    chk("t5_fault_led", led, 10'h200);
    chk("t5_rst_n_high", eng_rst_n, 1);
    eng_ready = 1'b1;
    cyc();
    chk("t5_fault_sticky", led, 10'h200);

    // Test 6: rst_n mid-WAIT restarts from ASSERT
    eng_ready = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < H + 1; i++) cyc();
    chk("t6_in_wait", led[1], 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("t6_rst_n", eng_rst_n, 0);
    chk("t6_led", led, 10'h001);
    chk("t6_err", seq_error, 0);
    chk("t6_busy", seq_busy, 1);

    // Randomized run against the model
    key_left = 0; rdy_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (key_left == 0) begin
        key0_n = 1'($urandom_range(0, 1));
        key_left = $urandom_range(1, 14);
      end
      if (rdy_left == 0) begin
        eng_ready = 1'($urandom_range(0, 1));
        rdy_left = $urandom_range(1, 20);
      end
      rst_n = ($urandom_range(0, 299) != 0);
      key_left--; rdy_left--;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
